ps2_keyboard: RTL and testbench
===============================

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 Parameter FILTER, default 8: clk14 cycles ps2_clk must hold a new level before it is accepted.
REQ-002 Parameter TIMEOUT, default 14000: clk14 cycles allowed between accepted falling edges inside a frame (about 1 ms).
REQ-003 clk14  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  CPU bus clock-enable strobe.
REQ-006 address  input  1  register select: 0 = KBD data, 1 = KBDCR status.
REQ-007 r_en  input  1  active-high read strobe.
REQ-008 ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous.
REQ-009 ps2_data  input  1  raw PS/2 data from keyboard, asynchronous.
REQ-010 dout  output  8  CPU read data.
REQ-011 key_ready  output  1  high while an unread character is latched.
REQ-012 frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer.
REQ-014 The filtered clock SHALL change only after the synchronized ps2_clk holds the opposite level for FILTER consecutive cycles; an accepted falling edge is a filtered 1->0 transition.
REQ-015 Receive FSM states: IDLE, DATA, PARITY, STOP. Synchronized ps2_data SHALL be sampled on each accepted falling edge.
REQ-016 IDLE -> DATA when the sample is 0 (start bit); a sample of 1 SHALL leave the FSM in IDLE with no error.
REQ-017 DATA SHALL shift in 8 bits LSB first, then go to PARITY; PARITY SHALL store the bit, then go to STOP.
REQ-018 In STOP, the frame SHALL be accepted only if the stop bit is 1 and the parity over the data and parity bits is odd. Otherwise frame_err SHALL pulse one cycle and the byte SHALL be discarded. Either way the FSM returns to IDLE.
REQ-019 Timeout: outside IDLE, TIMEOUT cycles with no accepted falling edge SHALL force IDLE and discard the partial frame, with no frame_err.
REQ-020 Decoder: byte 0xF0 SHALL set the break flag. Byte 0xE0 SHALL set the extended flag. Any other byte SHALL be consumed and then clear both flags.
REQ-021 Make of 0x12 or 0x59 SHALL set shift; break of either SHALL clear it. All other break codes and all extended codes SHALL produce no character.
REQ-022 Translation uses set-2 scancodes and a US layout. Every output character SHALL have bit 7 set.
REQ-023 Letters SHALL always map to uppercase 0xC1-0xDA. Digits SHALL map to 0xB0-0xB9, or to US shifted symbols when shift is set.
REQ-024 Punctuation , . / ; ' - = SHALL map per US layout, with shifted variants when shift is set.
REQ-025 Fixed codes: 0x29 -> 0xA0, 0x5A -> 0x8D, 0x66 -> 0xDF, 0x76 -> 0x9B.
REQ-026 Unmapped make codes SHALL produce no character. Typematic repeated make codes SHALL each produce a character.
REQ-027 Latency: a mapped character SHALL be in data_reg, with key_ready = 1, exactly 2 clk14 cycles after the accepted falling edge of its stop bit.
REQ-028 A new character arriving while key_ready = 1 SHALL overwrite data_reg (newest wins), and key_ready SHALL stay 1.
REQ-029 dout SHALL be combinational: address 0 -> data_reg; address 1 -> {key_ready, 7'b0}.
REQ-030 enable & r_en & address==0 SHALL clear key_ready on the next edge. Reads of address 1 SHALL have no side effect.
REQ-031 If the read-clear and a new character latch in the same cycle, the new character SHALL win: data_reg is updated and key_ready stays 1.

Reset
REQ-032 On rst, all registers SHALL reset to the following values:
- FSM IDLE, bit counter 0, filtered clock 1, timeout counter 0;
- break, extended and shift flags 0;
- data_reg 0x00, key_ready 0, frame_err 0, so dout = 0x00 at both addresses.
REQ-033 rst asserted mid-frame SHALL discard the frame. The first frame after release SHALL decode normally.

Verification
REQ-034 Frame 0x1C (A) with odd parity -> key_ready = 1 two cycles after the stop edge; address 0 reads 0xC1; address 1 reads 0x80.
REQ-035 Read address 0 with enable & r_en -> key_ready = 0 next cycle; address 1 then reads 0x00.
REQ-036 Sequence 0x12, 0x16, 0xF0 0x16, 0xF0 0x12, 0x16 -> characters 0xA1 then 0xB1; the break codes produce no character.
REQ-037 Frame 0x1C with bad parity -> frame_err pulses once and key_ready stays 0. A frame with stop = 0 gives the same result.
REQ-038 Four bits of a frame, then idle for TIMEOUT+10 cycles, then a full frame 0x5A -> only 0x8D is latched, with no frame_err.
REQ-039 1-cycle ps2_clk glitches during IDLE -> no FSM state change.
REQ-040 Read-clear in the same cycle as a new 0x29 latch -> key_ready = 1 and address 0 reads 0xA0.

Source files
------------

// File: rtl/ps2_keyboard.sv
// PS/2 set-2 keyboard receiver with a US-layout ASCII translator (bit 7 set)
// and a two-register CPU read port: KBD data at address 0, KBDCR status at address 1.
module ps2_keyboard #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 14000
) (
  input  logic       clk14,
  input  logic       rst,
  input  logic       enable,
  input  logic       address,
  input  logic       r_en,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] dout,
  output logic       key_ready,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]    clk_sync, dat_sync;
  logic          fclk, fall;
  logic [FW-1:0] fcnt;
  logic [1:0]    state;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          rx_valid;
  logic          brk, ext, shift;
  logic [7:0]    data_reg;
  logic [8:0]    xl;

  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // fall is registered so the data sample happens one cycle after the filtered edge
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      fclk <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] != fclk) begin
        if (fcnt == FW'(FILTER - 1)) begin
          fclk <= clk_sync[1];
          fcnt <= '0;
          fall <= fclk;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bcnt      <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tcnt      <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (state)
          IDLE: if (!dat_sync[1]) begin
            state <= DATA;
            bcnt  <= '0;
          end
          DATA: begin
            shreg <= {dat_sync[1], shreg[7:1]};
            bcnt  <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_sync[1];
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            if (dat_sync[1] && (^{shreg, par})) rx_valid  <= 1'b1;
            else                                frame_err <= 1'b1;
          end
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TW'(TIMEOUT - 1)) begin
          state <= IDLE;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end

  // {hit, character}; character always carries bit 7
  function automatic logic [8:0] xlate(input logic [7:0] c, input logic sh);
    logic [6:0] a;
    logic       hit;
    a   = '0;
    hit = 1'b1;
    case (c)
      8'h1C: a = 7'h41; 8'h32: a = 7'h42; 8'h21: a = 7'h43; 8'h23: a = 7'h44;
      8'h24: a = 7'h45; 8'h2B: a = 7'h46; 8'h34: a = 7'h47; 8'h33: a = 7'h48;
      8'h43: a = 7'h49; 8'h3B: a = 7'h4A; 8'h42: a = 7'h4B; 8'h4B: a = 7'h4C;
      8'h3A: a = 7'h4D; 8'h31: a = 7'h4E; 8'h44: a = 7'h4F; 8'h4D: a = 7'h50;
      8'h15: a = 7'h51; 8'h2D: a = 7'h52; 8'h1B: a = 7'h53; 8'h2C: a = 7'h54;
      8'h3C: a = 7'h55; 8'h2A: a = 7'h56; 8'h1D: a = 7'h57; 8'h22: a = 7'h58;
      8'h35: a = 7'h59; 8'h1A: a = 7'h5A;
      8'h45: a = sh ? 7'h29 : 7'h30;
      8'h16: a = sh ? 7'h21 : 7'h31;
      8'h1E: a = sh ? 7'h40 : 7'h32;
      8'h26: a = sh ? 7'h23 : 7'h33;
      8'h25: a = sh ? 7'h24 : 7'h34;
      8'h2E: a = sh ? 7'h25 : 7'h35;
      8'h36: a = sh ? 7'h5E : 7'h36;
      8'h3D: a = sh ? 7'h26 : 7'h37;
      8'h3E: a = sh ? 7'h2A : 7'h38;
      8'h46: a = sh ? 7'h28 : 7'h39;
      8'h41: a = sh ? 7'h3C : 7'h2C;
      8'h49: a = sh ? 7'h3E : 7'h2E;
      8'h4A: a = sh ? 7'h3F : 7'h2F;
      8'h4C: a = sh ? 7'h3A : 7'h3B;
      8'h52: a = sh ? 7'h22 : 7'h27;
      8'h4E: a = sh ? 7'h5F : 7'h2D;
      8'h55: a = sh ? 7'h2B : 7'h3D;
      8'h29: a = 7'h20;
      8'h5A: a = 7'h0D;
      8'h66: a = 7'h5F;
      8'h76: a = 7'h1B;
      default: hit = 1'b0;
    endcase
    return {hit, 1'b1, a};
  endfunction

  assign xl = xlate(shreg, shift);

  // a latch later in this block overrides the read-clear in the same cycle
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      brk       <= 1'b0;
      ext       <= 1'b0;
      shift     <= 1'b0;
      data_reg  <= '0;
      key_ready <= 1'b0;
    end else begin
      if (enable && r_en && !address) key_ready <= 1'b0;
      if (rx_valid) begin
        if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (!ext) begin
            if (shreg == 8'h12 || shreg == 8'h59) begin
              shift <= !brk;
            end else if (!brk && xl[8]) begin
              data_reg  <= xl[7:0];
              key_ready <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign dout = address ? {key_ready, 7'b0} : data_reg;
endmodule

// File: tb/tb_ps2_keyboard.sv
// Randomized self-checking bench for ps2_keyboard against a byte-level
// decoder model built from US set-2 key tables.
module tb_ps2_keyboard;
  localparam int FIL  = 8;
  localparam int TMO  = 400;
  localparam int HALF = 20;

  logic clk14 = 0, rst = 1, enable = 0, address = 0, r_en = 0;
  logic ps2_clk = 1, ps2_data = 1;
  logic [7:0] dout;
  logic key_ready, frame_err;

  int checks = 0, errors = 0;
  int fe_pulses = 0, fe_cycles = 0;
  logic fe_prev = 0;

  bit m_ready, m_brk, m_ext, m_shift;
  logic [7:0] m_data;

  logic [7:0] lc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                          8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                          8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] dc [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] pc [7]  = '{8'h41,8'h49,8'h4A,8'h4C,8'h52,8'h4E,8'h55};
  logic [7:0] fx [4]  = '{8'h29,8'h5A,8'h66,8'h76};
  logic [7:0] fxc [4] = '{8'hA0,8'h8D,8'hDF,8'h9B};
  logic [7:0] um [5]  = '{8'h05,8'h06,8'h0D,8'h14,8'h11};
  string dsh = ")!@#$%^&*(";
  string pun = ",./;'-=";
  string psh = "<>?:\"_+";

  ps2_keyboard #(.FILTER(FIL), .TIMEOUT(TMO)) dut (
    .clk14(clk14), .rst(rst), .enable(enable), .address(address), .r_en(r_en),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .dout(dout),
    .key_ready(key_ready), .frame_err(frame_err)
  );

  always #5 clk14 = ~clk14;

  always @(negedge clk14) begin
    if (frame_err) fe_cycles <= fe_cycles + 1;
    if (frame_err && !fe_prev) fe_pulses <= fe_pulses + 1;
    fe_prev <= frame_err;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int tr(input logic [7:0] c, input bit sh);
    for (int i = 0; i < 26; i++) if (c == lc[i]) return 'hC1 + i;
    for (int i = 0; i < 10; i++) if (c == dc[i]) return sh ? (int'(dsh[i]) | 'h80) : 'hB0 + i;
    for (int i = 0; i < 7; i++)  if (c == pc[i]) return sh ? (int'(psh[i]) | 'h80) : (int'(pun[i]) | 'h80);
    for (int i = 0; i < 4; i++)  if (c == fx[i]) return int'(fxc[i]);
    return -1;
  endfunction

  function automatic logic [7:0] pick_mapped();
    int r;
    r = $urandom_range(0, 42);
    if (r < 26) return lc[r];
    if (r < 36) return dc[r-26];
    return pc[r-36];
  endfunction

  task automatic model_byte(input logic [7:0] c);
    int ch;
    if (c == 8'hF0) m_brk = 1;
    else if (c == 8'hE0) m_ext = 1;
    else begin
      if (!m_ext) begin
        if (c == 8'h12 || c == 8'h59) m_shift = !m_brk;
        else if (!m_brk) begin
          ch = tr(c, m_shift);
          if (ch >= 0) begin m_data = ch[7:0]; m_ready = 1; end
        end
      end
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_brk = 0; m_ext = 0; m_shift = 0; m_data = 8'h00;
  endtask

  // mode 1: check key_ready is low 11 cycles and high 12 cycles after the stop-bit clock drop
  // mode 2: read-clear strobe coincides with the latch edge
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int mode);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk14); ps2_data = f[i];
      repeat (HALF) @(negedge clk14);
      ps2_clk = 0;
      if (i == 10 && mode != 0) begin
        repeat (11) @(posedge clk14);
        #1;
        if (mode == 1) begin
          checks++;
          if (key_ready !== 1'b0) begin errors++; $display("FAIL latency_early key_ready=%b want 0", key_ready); end
        end else begin
          address = 0; enable = 1; r_en = 1;
        end
        @(posedge clk14); #1;
        enable = 0; r_en = 0;
        checks++;
        if (key_ready !== 1'b1) begin errors++; $display("FAIL latency_mode%0d key_ready=%b want 1", mode, key_ready); end
      end
      repeat (HALF) @(negedge clk14);
      ps2_clk = 1;
    end
    repeat (HALF) @(negedge clk14);
    ps2_data = 1;
  endtask

  task automatic read_clear();
    @(negedge clk14); address = 0; enable = 1; r_en = 1;
    @(negedge clk14); enable = 0; r_en = 0;
    m_ready = 0;
  endtask

  task automatic check_model(input string nm);
    address = 0; #1;
    checks++;
    if (key_ready !== m_ready) begin errors++; $display("FAIL %s key_ready=%b want %b", nm, key_ready, m_ready); end
    checks++;
    if (dout !== m_data) begin errors++; $display("FAIL %s data=%h want %h", nm, dout, m_data); end
    address = 1; #1;
    checks++;
    if (dout !== {m_ready, 7'b0}) begin errors++; $display("FAIL %s status=%h want %h", nm, dout, {m_ready, 7'b0}); end
    address = 0;
  endtask

  task automatic do_reset();
    @(negedge clk14); rst = 1; ps2_clk = 1; ps2_data = 1;
    repeat (3) @(negedge clk14); rst = 0;
    model_reset();
    repeat (3) @(negedge clk14);
  endtask

  task automatic test_reset();
    do_reset();
    address = 0; #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", dout); end
    address = 1; #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", dout); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    address = 0;
  endtask

  task automatic test_basic();
    send_frame(8'h1C, 0, 0, 11, 1); model_byte(8'h1C);
    address = 0; #1;
    checks++; if (dout !== 8'hC1) begin errors++; $display("FAIL basic_data got %h want C1", dout); end
    address = 1; #1;
    checks++; if (dout !== 8'h80) begin errors++; $display("FAIL basic_status got %h want 80", dout); end
    @(negedge clk14); enable = 1; r_en = 1;
    @(negedge clk14); enable = 0; r_en = 0;
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL status_read_side_effect key_ready=%b want 1", key_ready); end
    read_clear();
    address = 1; #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL clear_status got %h want 00", dout); end
    address = 0;
    check_model("basic");
  endtask

  task automatic test_shift_seq();
    logic [7:0] seq [7] = '{8'h12, 8'h16, 8'hF0, 8'h16, 8'hF0, 8'h12, 8'h16};
    for (int i = 0; i < 7; i++) begin
      send_frame(seq[i], 0, 0, 11, 0); model_byte(seq[i]);
      address = 0; #1;
      if (i == 1) begin
        checks++; if (dout !== 8'hA1 || key_ready !== 1'b1) begin errors++; $display("FAIL shifted_one got %h/%b want A1/1", dout, key_ready); end
        read_clear();
      end
      if (i == 3 || i == 5) begin
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL break_no_char step%0d key_ready=%b want 0", i, key_ready); end
      end
      if (i == 6) begin
        checks++; if (dout !== 8'hB1 || key_ready !== 1'b1) begin errors++; $display("FAIL unshifted_one got %h/%b want B1/1", dout, key_ready); end
      end
    end
    check_model("shift_seq");
  endtask

  task automatic test_frame_err();
    int p0, c0;
    read_clear();
    for (int k = 0; k < 2; k++) begin
      p0 = fe_pulses; c0 = fe_cycles;
      send_frame(8'h1C, k == 0, k == 1, 11, 0);
      checks++; if (fe_pulses - p0 != 1) begin errors++; $display("FAIL frame_err_pulses case%0d got %0d want 1", k, fe_pulses - p0); end
      checks++; if (fe_cycles - c0 != 1) begin errors++; $display("FAIL frame_err_width case%0d got %0d want 1", k, fe_cycles - c0); end
      checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL frame_err_ready case%0d key_ready=%b want 0", k, key_ready); end
    end
  endtask

  task automatic test_timeout();
    int p0;
    read_clear();
    p0 = fe_pulses;
    send_frame(8'h33, 0, 0, 4, 0);
    repeat (TMO + 10) @(negedge clk14);
    send_frame(8'h5A, 0, 0, 11, 0); model_byte(8'h5A);
    address = 0; #1;
    checks++; if (dout !== 8'h8D || key_ready !== 1'b1) begin errors++; $display("FAIL timeout_recover got %h/%b want 8D/1", dout, key_ready); end
    checks++; if (fe_pulses != p0) begin errors++; $display("FAIL timeout_frame_err got %0d want 0", fe_pulses - p0); end
  endtask

  task automatic test_glitch();
    int p0;
    read_clear();
    p0 = fe_pulses;
    ps2_data = 0;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk14); ps2_clk = 0;
      @(negedge clk14); ps2_clk = 1;
      repeat (5) @(negedge clk14);
    end
    ps2_data = 1;
    repeat (HALF) @(negedge clk14);
    send_frame(8'h1C, 0, 0, 11, 0); model_byte(8'h1C);
    address = 0; #1;
    checks++; if (dout !== 8'hC1 || key_ready !== 1'b1) begin errors++; $display("FAIL glitch_frame got %h/%b want C1/1", dout, key_ready); end
    checks++; if (fe_pulses != p0) begin errors++; $display("FAIL glitch_frame_err got %0d want 0", fe_pulses - p0); end
  endtask

  task automatic test_read_race();
    send_frame(8'h29, 0, 0, 11, 2); model_byte(8'h29);
    address = 0; #1;
    checks++; if (dout !== 8'hA0) begin errors++; $display("FAIL race_data got %h want A0", dout); end
    check_model("race");
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h12, 0, 0, 6, 0);
    do_reset();
    check_model("midreset");
    send_frame(8'h1C, 0, 0, 11, 0); model_byte(8'h1C);
    address = 0; #1;
    checks++; if (dout !== 8'hC1) begin errors++; $display("FAIL after_reset got %h want C1", dout); end
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    int r, p0;
    bit bad;
    for (int n = 0; n < 40; n++) begin
      q.delete();
      bad = 0;
      r = $urandom_range(0, 10);
      case (r)
        0, 1, 2: q.push_back(lc[$urandom_range(0, 25)]);
        3: q.push_back(dc[$urandom_range(0, 9)]);
        4: q.push_back(pc[$urandom_range(0, 6)]);
        5: q.push_back(fx[$urandom_range(0, 3)]);
        6: q.push_back($urandom_range(0, 1) ? 8'h12 : 8'h59);
        7: begin q.push_back(8'hF0); q.push_back($urandom_range(0, 1) ? pick_mapped() : 8'h12); end
        8: begin q.push_back(8'hE0); if ($urandom_range(0, 1)) q.push_back(8'hF0); q.push_back(pick_mapped()); end
        9: q.push_back(um[$urandom_range(0, 4)]);
        default: begin bad = 1; q.push_back(pick_mapped()); end
      endcase
      p0 = fe_pulses;
      foreach (q[i]) begin
        send_frame(q[i], bad, 0, 11, 0);
        if (!bad) model_byte(q[i]);
      end
      checks++;
      if (fe_pulses - p0 != int'(bad)) begin errors++; $display("FAIL rand%0d frame_err got %0d want %0d", n, fe_pulses - p0, bad); end
      check_model($sformatf("rand%0d", n));
      if ($urandom_range(0, 2) == 0) read_clear();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_shift_seq();
    test_frame_err();
    test_timeout();
    test_glitch();
    test_read_race();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
